// File: rtl/hex_frac_mul_pkg.sv
// Shared definitions for the hex fraction multiplier: widths, FSM states
// and the dividend recovery helper.
package hex_frac_mul_pkg;

  localparam int DIGIT_W = 4;
  localparam int FRAC_W  = 16;
  localparam int PROD_W  = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recovered dividend: ceil-style rounding (P + B - 1) >> 16, zero when B is 0
  function automatic logic [DIGIT_W-1:0] recover_a(input logic [PROD_W-1:0]  prod,
                                                   input logic [DIGIT_W-1:0] b);
    logic [PROD_W:0] t;
    t = '0;
    if (b == '0) begin
      return '0;
    end
    t = {1'b0, prod} + (PROD_W+1)'(b) - (PROD_W+1)'(1);
    return t[PROD_W-1 -: DIGIT_W];
  endfunction

endpackage

// File: rtl/hex_frac_mul_if.sv
// Operand/result handshake bundle for the hex fraction multiplier.
interface hex_frac_mul_if;
  import hex_frac_mul_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [FRAC_W-1:0]   in_q;
  logic [DIGIT_W-1:0]  in_b;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   out_product;
  logic [DIGIT_W-1:0]  out_a;
  logic                out_err;

  modport master (
    output in_valid, in_q, in_b, out_ready,
    input  in_ready, out_valid, out_product, out_a, out_err
  );

  modport slave (
    input  in_valid, in_q, in_b, out_ready,
    output in_ready, out_valid, out_product, out_a, out_err
  );

endinterface

// File: rtl/hex_digit_mac.sv
// Combinational radix-16 multiply-accumulate step: (acc << 4) + d*b.
module hex_digit_mac
  import hex_frac_mul_pkg::*;
(
  input  logic [PROD_W-1:0]  acc,
  input  logic [DIGIT_W-1:0] d,
  input  logic [DIGIT_W-1:0] b,
  output logic [PROD_W-1:0]  acc_out
);

  logic [2*DIGIT_W-1:0] dprod;

  // Digit product is 8 bits, zero-extended before the add
  always_comb begin
    dprod   = d * b;
    acc_out = {acc[PROD_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}} + PROD_W'(dprod);
  end

endmodule

// File: rtl/hex_frac_mul.sv
// Digit-serial radix-16 multiplier: rebuilds P = Q*B one hex digit per cycle,
// MSB first, and recovers the original dividend from the product.
module hex_frac_mul #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  hex_frac_mul_if.slave bus
);
  import hex_frac_mul_pkg::PROD_W;
  import hex_frac_mul_pkg::FRAC_W;
  import hex_frac_mul_pkg::state_t;
  import hex_frac_mul_pkg::IDLE;
  import hex_frac_mul_pkg::STEP;
  import hex_frac_mul_pkg::DONE;
  import hex_frac_mul_pkg::recover_a;

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t               state, state_n;
  logic [FRAC_W-1:0]    q_sh;
  logic [DIGIT_W-1:0]   b_r;
  logic [PROD_W-1:0]    acc;
  logic [PROD_W-1:0]    acc_next;
  logic [CNT_W-1:0]     cnt;
  logic [PROD_W-1:0]    product_r;
  logic [DIGIT_W-1:0]   a_r;
  logic                 err_r;

  hex_digit_mac u_mac (
    .acc     (acc),
    .d       (q_sh[FRAC_W-1 -: DIGIT_W]),
    .b       (b_r),
    .acc_out (acc_next)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_n          = state;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_product  = product_r;
    bus.out_a        = a_r;
    bus.out_err      = err_r;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = STEP;
      end
      STEP: begin
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, digit-serial accumulation and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sh      <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_r <= '0;
      a_r       <= '0;
      err_r     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_sh <= bus.in_q;
            b_r  <= bus.in_b;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        STEP: begin
          acc  <= acc_next;
          q_sh <= q_sh << DIGIT_W;
          cnt  <= cnt + 1'b1;
          // Results load straight from the final MAC output on the STEP->DONE edge
          if (cnt == LAST) begin
            err_r     <= (b_r == '0);
            product_r <= (b_r == '0) ? '0 : acc_next;
            a_r       <= recover_a(acc_next, b_r);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
